// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared types and helpers for the UART transmit path       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Clocks per bit, rounded to nearest.
   function automatic int calc_div(input int clk_freq, input int baud);
      return (clk_freq + baud / 2) / baud;
   endfunction

   function automatic logic calc_parity(input logic [7:0] data, input int mode);
      case (mode)
         PAR_ODD:  return ~^data;
         PAR_EVEN: return ^data;
         default:  return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with register-array storage            |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int               c_AW   = $clog2(DEPTH);
   localparam logic [c_AW:0]    c_FULL = (c_AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign empty  = (r_count == '0);
   assign full   = (r_count == c_FULL);
   assign count  = r_count;
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   // Head comes straight out of the storage registers, no read latency.
   assign dout   = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx : buffered UART transmitter, FIFO front end + frame FSM       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx
   import uart_pkg::tx_state_t, uart_pkg::IDLE, uart_pkg::START, uart_pkg::DATA,
          uart_pkg::STOP, uart_pkg::PAR_NONE, uart_pkg::calc_div, uart_pkg::calc_parity;
#(
   parameter int CLK_FREQ   = 200_000_000,
   parameter int BAUD       = 115200,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_readyo,
   output logic                          uart_txo,
   output logic                          busyo,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_counto
);

   localparam int             c_DIV       = calc_div(CLK_FREQ, BAUD);
   localparam int             c_CW        = $clog2(c_DIV);
   localparam logic [c_CW-1:0] c_DIV_M1   = c_CW'(c_DIV - 1);
   localparam logic [2:0]     c_LAST_STOP = 3'(STOP_BITS - 1);

   tx_state_t       r_state;
   tx_state_t       w_next;
   logic [c_CW-1:0] r_baud;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic            r_par;
   logic            r_txo;
   logic            r_busy;
   logic            w_bit_end;
   logic            w_pop;
   logic            w_line;
   logic [7:0]      w_head;
   logic            w_empty;
   logic            w_full;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_valid),
      .din   (tx_data),
      .pop   (w_pop),
      .dout  (w_head),
      .empty (w_empty),
      .full  (w_full),
      .count (fifo_counto)
   );

   assign tx_readyo = !w_full;
   assign uart_txo  = r_txo;
   assign busyo     = r_busy;
   assign w_bit_end = (r_baud == c_DIV_M1);

   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      w_line = 1'b1;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop  = 1'b1;
               w_next = START;
            end
         end
         START: begin
            w_line = 1'b0;
            if (w_bit_end) w_next = DATA;
         end
         DATA: begin
            w_line = r_shift[0];
            if (w_bit_end && r_bit == 3'd7) begin
               w_next = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            end
         end
         uart_pkg::PARITY: begin
            w_line = r_par;
            if (w_bit_end) w_next = STOP;
         end
         STOP: begin
            // Chain straight into the next start bit when more data is waiting.
            if (w_bit_end && r_bit == c_LAST_STOP) begin
               if (!w_empty) begin
                  w_pop  = 1'b1;
                  w_next = START;
               end else begin
                  w_next = IDLE;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_txo   <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         // Line and busy are registered together so busy tracks the wire.
         r_txo   <= w_line;
         r_busy  <= (r_state != IDLE) || !w_empty;

         if (r_state == IDLE || w_bit_end) r_baud <= '0;
         else                              r_baud <= r_baud + 1'b1;

         if (w_next != r_state) r_bit <= '0;
         else if (w_bit_end)    r_bit <= r_bit + 1'b1;

         if (w_pop) begin
            r_shift <= w_head;
            r_par   <= calc_parity(w_head, PARITY);
         end else if (r_state == DATA && w_bit_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Buffered UART transmitter: accepts bytes over a valid/ready handshake into a small FIFO.
- Serializes each byte onto uart_txo as 8N1, with configurable parity and stop bits.
- Sits in the 200 MHz domain next to the UART receive path. It is the transmit end of the same serial link, driven by the echo/command logic.

Parameters:
- CLK_FREQ, 200_000_000: input clock frequency in Hz.
- BAUD, 115200: line rate in bit/s. DIV = (CLK_FREQ + BAUD/2) / BAUD clocks per bit; must be >= 4.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- tx_data  input  8  byte to send.
- tx_valid  input  1  tx_data is valid.
- tx_readyo  output  1  FIFO can accept; a transfer occurs when tx_valid && tx_readyo at a rising edge.
- uart_txo  output  1  serial line, idle high, registered.
- busyo  output  1  FSM not IDLE or FIFO non-empty.
- fifo_counto  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (asynchronous, while reset==0): uart_txo=1, tx_readyo=1, busyo=0, fifo_counto=0. FSM=IDLE, baud counter=0, bit index=0, FIFO pointers=0.
- tx_readyo = !full, combinational from FIFO count. A push while full is impossible by construction.
- Push and pop in the same cycle are allowed at any occupancy except: push-when-full is blocked, pop-when-empty never happens. Count is unchanged on simultaneous push and pop.
- Frame order: start (0), data bits LSB first, optional parity, STOP_BITS stop bits (1). Each bit holds uart_txo for exactly DIV clocks.
- Parity: even means parity bit = XOR of the data bits; odd means its inverse.
- FSM states and transitions:
  - IDLE: uart_txo=1. If FIFO non-empty, pop into the shift register and go to START.
  - START: drive 0 for DIV clocks, then go to DATA.
  - DATA: 8 bits; on the 8th bit end go to PARITY (if PARITY != 0) else STOP.
  - PARITY: one bit, then STOP.
  - STOP: STOP_BITS x DIV clocks. In the last clock of the final stop bit, if FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency: with FSM in IDLE and FIFO empty, the byte accepted at edge N is popped at edge N+1. uart_txo goes low after edge N+2.
- Baud counter counts 0..DIV-1, restarts at every bit boundary, and is held at 0 in IDLE.
- The FSM never samples tx_data directly; only FIFO contents are sent.
- Reset mid-frame: line returns high immediately; the FIFO and the in-flight byte are discarded. No partial frame resumes after release.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP};
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - function calc_div(clk_freq, baud).
- One sub-module, sync_fifo (parameters WIDTH, DEPTH): single-clock, same reset; outputs dout (registered head), empty, full, count.
- uart_tx holds the FSM, baud counter, shift register and parity.

Test Plan:
- CLK_FREQ=8_000_000, BAUD=1_000_000 (DIV=8), PARITY=0. Push 0x55 once from idle → uart_txo low from edge N+2 for 8 clk. Then data 1,0,1,0,1,0,1,0 at 8 clk each, then high. Frame = 80 clk; busyo drops the cycle after the stop bit ends.
- PARITY=2, push 0xA5 → parity bit 0. PARITY=1, push 0xA5 → parity bit 1. Frame = 88 clk in both cases.
- STOP_BITS=2, push 0x00, 0xFF back-to-back → exactly 16 high clocks between the two frames, no extra idle cycle. Total frame pair = 176 clk.
- DIV=8, FIFO_DEPTH=4, hold tx_valid with bytes 0x01..0x06 from idle → 5 bytes accepted (one drained to the shifter). tx_readyo=0 until the first frame ends; 0x06 is accepted the cycle after that pop. Bytes appear on the line in order 0x01..0x06.
- Assert reset during data bit 3 of 0x3C with 2 bytes queued → uart_txo=1, tx_readyo=1, busyo=0, fifo_counto=0 immediately. After release, the line stays high for 200 clk.
- Simultaneous push and pop at count=2 → fifo_counto stays 2, no byte lost or duplicated; verify with a scoreboard comparing the decoded line against the pushed stream.
